// File: rtl/pq_shift_array_pkg.sv
// Shared types for the shift-register priority queue.
package pq_shift_array_pkg;

    // Head ordering: MAX_PQ keeps the largest key at the head, MIN_PQ the smallest.
    typedef enum logic {
        MIN_PQ = 1'b0,
        MAX_PQ = 1'b1
    } pq_type_t;

endpackage

// File: rtl/pq_shift_array.sv
// Shift-register priority queue of <key,value> pairs; sorted by key, head in slot 0.
module pq_shift_array
    import pq_shift_array_pkg::*;
#(
    parameter int unsigned KEY_WIDTH   = 8,
    parameter int unsigned VAL_WIDTH   = 8,
    parameter int unsigned PQ_CAPACITY = 15,
    parameter pq_type_t    PQ_TYPE     = MAX_PQ,
    localparam int unsigned CNT_W      = $clog2(PQ_CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enq,
    input  logic                 deq,
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic [VAL_WIDTH-1:0] val_in,
    output logic [KEY_WIDTH-1:0] top_key,
    output logic [VAL_WIDTH-1:0] top_val,
    output logic                 top_valid,
    output logic [CNT_W-1:0]     count,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned IDX_W = $clog2(PQ_CAPACITY);

    logic                 vld_q [PQ_CAPACITY];
    logic                 vld_d [PQ_CAPACITY];
    logic [KEY_WIDTH-1:0] key_q [PQ_CAPACITY];
    logic [KEY_WIDTH-1:0] key_d [PQ_CAPACITY];
    logic [VAL_WIDTH-1:0] val_q [PQ_CAPACITY];
    logic [VAL_WIDTH-1:0] val_d [PQ_CAPACITY];
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic [IDX_W-1:0]     ins_p;
    logic                 found;

    // Strict priority compare; equal keys never beat each other, which keeps ties FIFO.
    function automatic logic beats(input logic [KEY_WIDTH-1:0] a,
                                   input logic [KEY_WIDTH-1:0] b);
        return (PQ_TYPE == MAX_PQ) ? (a > b) : (a < b);
    endfunction

    // Next-state for the slot array and status flags.
    always_comb begin
        vld_d       = vld_q;
        key_d       = key_q;
        val_d       = val_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        ins_p       = '0;
        found       = 1'b0;

        if (enq && deq && !empty_q) begin
            // Replace: head leaves, insertion point is taken in the post-shift array.
            ins_p = IDX_W'(PQ_CAPACITY - 1);
            for (int i = 1; i < int'(PQ_CAPACITY); i++) begin
                if (!found && (!vld_q[i] || beats(key_in, key_q[i]))) begin
                    ins_p = IDX_W'(i - 1);
                    found = 1'b1;
                end
            end
            for (int i = 0; i < int'(PQ_CAPACITY) - 1; i++) begin
                if (IDX_W'(i) < ins_p) begin
                    vld_d[i] = vld_q[i+1];
                    key_d[i] = key_q[i+1];
                    val_d[i] = val_q[i+1];
                end
            end
            vld_d[ins_p] = 1'b1;
            key_d[ins_p] = key_in;
            val_d[ins_p] = val_in;
        end else if (enq && !deq && full_q) begin
            overflow_d = 1'b1;
        end else if (enq) begin
            // Plain insert (also covers replace on an empty queue); tail slot is free.
            for (int i = 0; i < int'(PQ_CAPACITY); i++) begin
                if (!found && (!vld_q[i] || beats(key_in, key_q[i]))) begin
                    ins_p = IDX_W'(i);
                    found = 1'b1;
                end
            end
            for (int i = 1; i < int'(PQ_CAPACITY); i++) begin
                if (IDX_W'(i) > ins_p) begin
                    vld_d[i] = vld_q[i-1];
                    key_d[i] = key_q[i-1];
                    val_d[i] = val_q[i-1];
                end
            end
            vld_d[ins_p] = 1'b1;
            key_d[ins_p] = key_in;
            val_d[ins_p] = val_in;
            count_d      = count_q + CNT_W'(1);
        end else if (deq && !empty_q) begin
            for (int i = 0; i < int'(PQ_CAPACITY) - 1; i++) begin
                vld_d[i] = vld_q[i+1];
                key_d[i] = key_q[i+1];
                val_d[i] = val_q[i+1];
            end
            vld_d[PQ_CAPACITY-1] = 1'b0;
            key_d[PQ_CAPACITY-1] = '0;
            val_d[PQ_CAPACITY-1] = '0;
            count_d              = count_q - CNT_W'(1);
        end else if (deq) begin
            underflow_d = 1'b1;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(PQ_CAPACITY));
    end

    // State registers; reset clears every slot and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PQ_CAPACITY); i++) begin
                vld_q[i] <= 1'b0;
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            key_q       <= key_d;
            val_q       <= val_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign top_key   = key_q[0];
    assign top_val   = val_q[0];
    assign top_valid = vld_q[0];
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_pq_shift_array.sv
// Scoreboard bench for pq_shift_array: one MAX and one MIN instance, capacity 4.
module tb_pq_shift_array;
    import pq_shift_array_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enq_a = 1'b0, deq_a = 1'b0, enq_b = 1'b0, deq_b = 1'b0;
    logic [7:0] key_in = '0, val_in = '0;

    logic [7:0] tk_a, tv_a, tk_b, tv_b;
    logic [2:0] cnt_a, cnt_b;
    logic       vld_a, emp_a, ful_a, ovf_a, unf_a;
    logic       vld_b, emp_b, ful_b, ovf_b, unf_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        bit          mn;
        logic [23:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pq_shift_array #(.KEY_WIDTH(8), .VAL_WIDTH(8), .PQ_CAPACITY(4), .PQ_TYPE(MAX_PQ)) dut_a (
        .clk(clk), .rst_n(rst_n), .enq(enq_a), .deq(deq_a), .key_in(key_in), .val_in(val_in),
        .top_key(tk_a), .top_val(tv_a), .top_valid(vld_a), .count(cnt_a),
        .empty(emp_a), .full(ful_a), .overflow(ovf_a), .underflow(unf_a));

    pq_shift_array #(.KEY_WIDTH(8), .VAL_WIDTH(8), .PQ_CAPACITY(4), .PQ_TYPE(MIN_PQ)) dut_b (
        .clk(clk), .rst_n(rst_n), .enq(enq_b), .deq(deq_b), .key_in(key_in), .val_in(val_in),
        .top_key(tk_b), .top_val(tv_b), .top_valid(vld_b), .count(cnt_b),
        .empty(emp_b), .full(ful_b), .overflow(ovf_b), .underflow(unf_b));

    // Observed outputs packed as {top_key, top_val, top_valid, count, full, empty, overflow, underflow}.
    function automatic logic [23:0] observe(input bit mn);
        if (mn) return {tk_b, tv_b, vld_b, cnt_b, ful_b, emp_b, ovf_b, unf_b};
        return {tk_a, tv_a, vld_a, cnt_a, ful_a, emp_a, ovf_a, unf_a};
    endfunction

    task automatic chk(input string nm, input bit mn, input logic [23:0] exp);
        logic [23:0] act;
        act = observe(mn);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got key=%0d val=%0d vld=%0b cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b, want key=%0d val=%0d vld=%0b cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                     nm, act[23:16], act[15:8], act[7], act[6:4], act[3], act[2], act[1], act[0],
                     exp[23:16], exp[15:8], exp[7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one operation for one cycle and queue the state expected after that edge.
    task automatic op(input bit mn, input bit e, input bit d, input int k, input int v,
                      input string nm, input int tk, input int tv, input int cnt,
                      input bit fl, input bit ov, input bit un);
        exp_t x;
        @(negedge clk);
        enq_a  = e && !mn;
        deq_a  = d && !mn;
        enq_b  = e && mn;
        deq_b  = d && mn;
        key_in = 8'(k);
        val_in = 8'(v);
        x.nm   = nm;
        x.mn   = mn;
        x.exp  = {8'(tk), 8'(tv), cnt != 0, 3'(cnt), fl, cnt == 0, ov, un};
        sb.push_back(x);
    endtask

    task automatic fill_9752();
        op(0, 1, 0, 5, 5, "fill5", 5, 5, 1, 0, 0, 0);
        op(0, 1, 0, 9, 9, "fill9", 9, 9, 2, 0, 0, 0);
        op(0, 1, 0, 2, 2, "fill2", 9, 9, 3, 0, 0, 0);
        op(0, 1, 0, 7, 7, "fill7", 9, 9, 4, 1, 0, 0);
    endtask

    // Monitor: just after each edge, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk(x.nm, x.mn, x.exp);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        op(0, 0, 0, 0, 0, "reset_state", 0, 0, 0, 0, 0, 0);

        // Sorted insert and dequeue order.
        fill_9752();
        op(0, 0, 1, 0, 0, "deq9", 7, 7, 3, 0, 0, 0);
        op(0, 0, 1, 0, 0, "deq7", 5, 5, 2, 0, 0, 0);
        op(0, 0, 1, 0, 0, "deq5", 2, 2, 1, 0, 0, 0);
        op(0, 0, 1, 0, 0, "deq2", 0, 0, 0, 0, 0, 0);

        // Equal keys leave in arrival order.
        op(0, 1, 0, 4, 1, "tie1", 4, 1, 1, 0, 0, 0);
        op(0, 1, 0, 4, 2, "tie2", 4, 1, 2, 0, 0, 0);
        op(0, 1, 0, 4, 3, "tie3", 4, 1, 3, 0, 0, 0);
        op(0, 0, 1, 0, 0, "tie_deq1", 4, 2, 2, 0, 0, 0);
        op(0, 0, 1, 0, 0, "tie_deq2", 4, 3, 1, 0, 0, 0);
        op(0, 0, 1, 0, 0, "tie_deq3", 0, 0, 0, 0, 0, 0);

        // Overflow leaves contents alone; replace when full drops head and sorts new tail.
        fill_9752();
        op(0, 1, 0, 8, 8, "ovf_pulse", 9, 9, 4, 1, 1, 0);
        op(0, 0, 0, 0, 0, "ovf_clear", 9, 9, 4, 1, 0, 0);
        op(0, 1, 1, 1, 1, "repl_full", 7, 7, 4, 1, 0, 0);
        op(0, 0, 1, 0, 0, "rf_deq7", 5, 5, 3, 0, 0, 0);
        op(0, 0, 1, 0, 0, "rf_deq5", 2, 2, 2, 0, 0, 0);
        op(0, 0, 1, 0, 0, "rf_deq2", 1, 1, 1, 0, 0, 0);
        op(0, 0, 1, 0, 0, "rf_deq1", 0, 0, 0, 0, 0, 0);

        // Replace into the middle with a tie: new entry goes behind the equal key.
        op(0, 1, 0, 9, 9, "m9", 9, 9, 1, 0, 0, 0);
        op(0, 1, 0, 5, 5, "m5", 9, 9, 2, 0, 0, 0);
        op(0, 1, 0, 3, 3, "m3", 9, 9, 3, 0, 0, 0);
        op(0, 1, 1, 5, 55, "repl_mid", 5, 5, 3, 0, 0, 0);
        op(0, 0, 1, 0, 0, "rm_deq_a", 5, 55, 2, 0, 0, 0);
        op(0, 0, 1, 0, 0, "rm_deq_b", 3, 3, 1, 0, 0, 0);
        op(0, 0, 1, 0, 0, "rm_deq_c", 0, 0, 0, 0, 0, 0);

        // Empty-queue corner cases.
        op(0, 0, 1, 0, 0, "unf_pulse", 0, 0, 0, 0, 0, 1);
        op(0, 0, 0, 0, 0, "unf_clear", 0, 0, 0, 0, 0, 0);
        op(0, 1, 1, 3, 3, "repl_empty", 3, 3, 1, 0, 0, 0);

        // MIN ordering.
        op(1, 1, 0, 5, 5, "min5", 5, 5, 1, 0, 0, 0);
        op(1, 1, 0, 9, 9, "min9", 5, 5, 2, 0, 0, 0);
        op(1, 1, 0, 2, 2, "min2", 2, 2, 3, 0, 0, 0);

        // Asynchronous reset in the middle of an enqueue.
        @(negedge clk);
        enq_a = 1'b0; deq_a = 1'b0; deq_b = 1'b0;
        enq_b = 1'b1; key_in = 8'd1; val_in = 8'd1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_min", 1, 24'h000004);
        chk("async_rst_max", 0, 24'h000004);
        @(posedge clk);
        #1;
        chk("rst_held_min", 1, 24'h000004);
        @(negedge clk);
        enq_b = 1'b0;
        rst_n = 1'b1;
        op(1, 0, 1, 0, 0, "post_rst_unf", 0, 0, 0, 0, 0, 1);

        @(negedge clk);
        enq_a = 1'b0; deq_a = 1'b0; enq_b = 1'b0; deq_b = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations still queued, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
